// File: rtl/s3g_gpio_bank.sv
// N-channel programmable output bank: static, counter slice, one-shot pulse and square wave.
// Define GPIO_BANK_READBACK_EN to enable the registered {mode, arg} readback port.
module s3g_gpio_bank #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned CNT_BITS = 32,
  parameter int unsigned SEL_BITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [SEL_BITS-1:0]       cfg_sel,
  input  logic [31:0]               cfg_data,
  output logic [CHANNELS*WIDTH-1:0] out_bus,
  output logic [CHANNELS-1:0]       busy,
  input  logic [SEL_BITS-1:0]       rd_sel,
  output logic [31:0]               rd_data
);

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_SLICE  = 2'd1,
    M_PULSE  = 2'd2,
    M_SQUARE = 2'd3
  } mode_t;

  logic [CNT_BITS-1:0]       cnt_q;
  mode_t                     mode_q  [CHANNELS];
  mode_t                     mode_d  [CHANNELS];
  logic [29:0]               arg_q   [CHANNELS];
  logic [29:0]               arg_d   [CHANNELS];
  logic [29:0]               timer_q [CHANNELS];
  logic [29:0]               timer_d [CHANNELS];
  logic [CHANNELS-1:0]       phase_q, phase_d;
  logic [CHANNELS*WIDTH-1:0] out_q, out_d;
  logic [CHANNELS-1:0]       busy_q, busy_d;

  // Bits of the slice that fall above the counter's MSB shift in as zero.
  function automatic logic [WIDTH-1:0] slice_of(input logic [CNT_BITS-1:0] c,
                                                 input logic [4:0] s);
    logic [CNT_BITS+WIDTH-1:0] ext;
    ext = {{WIDTH{1'b0}}, c} >> s;
    return ext[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= '0;
      out_q   <= '0;
      busy_q  <= '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        mode_q[ch]  <= M_STATIC;
        arg_q[ch]   <= '0;
        timer_q[ch] <= '0;
      end
    end else begin
      cnt_q   <= cnt_q + CNT_BITS'(1);
      phase_q <= phase_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        mode_q[ch]  <= mode_d[ch];
        arg_q[ch]   <= arg_d[ch];
        timer_q[ch] <= timer_d[ch];
      end
    end
  end

  // A write overrides the timer/phase advance, so a rewrite restarts cleanly.
  always_comb begin
    phase_d = phase_q;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      mode_d[ch]  = mode_q[ch];
      arg_d[ch]   = arg_q[ch];
      timer_d[ch] = timer_q[ch];
      case (mode_q[ch])
        M_PULSE: begin
          if (timer_q[ch] < arg_q[ch]) timer_d[ch] = timer_q[ch] + 30'd1;
        end
        M_SQUARE: begin
          if (timer_q[ch] == arg_q[ch]) begin
            timer_d[ch] = '0;
            phase_d[ch] = ~phase_q[ch];
          end else begin
            timer_d[ch] = timer_q[ch] + 30'd1;
          end
        end
        default: ;
      endcase
      if (cfg_wr && (cfg_sel == SEL_BITS'(ch))) begin
        mode_d[ch]  = mode_t'(cfg_data[31:30]);
        arg_d[ch]   = cfg_data[29:0];
        timer_d[ch] = '0;
        phase_d[ch] = 1'b0;
      end
    end
  end

  always_comb begin
    out_d  = '0;
    busy_d = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      case (mode_q[ch])
        M_STATIC: out_d[ch*WIDTH +: WIDTH] = arg_q[ch][WIDTH-1:0];
        M_SLICE:  out_d[ch*WIDTH +: WIDTH] = slice_of(cnt_q, arg_q[ch][4:0]);
        M_PULSE: begin
          if (timer_q[ch] < arg_q[ch]) begin
            busy_d[ch]                 = 1'b1;
            out_d[ch*WIDTH +: WIDTH]   = '1;
          end
        end
        M_SQUARE: begin
          if (phase_q[ch]) out_d[ch*WIDTH +: WIDTH] = '1;
        end
        default: ;
      endcase
    end
  end

  assign out_bus = out_q;
  assign busy    = busy_q;

`ifdef GPIO_BANK_READBACK_EN
  logic [31:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (rd_sel == SEL_BITS'(ch)) rd_d = {mode_q[ch], arg_q[ch]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data = rd_q;
`else
  logic unused_rd_sel;
  assign unused_rd_sel = ^rd_sel;
  assign rd_data       = '0;
`endif

endmodule

// File: doc/s3g_gpio_bank.md
Name: s3g_gpio_bank

Overview:
- Parametrised N-channel output generator for the board headers and LEDs; it is driven from s3g_executor out_stbs/out_reg strobes.
- It generalises the fixed "free-running counter slice to header" wiring into per-channel, run-time programmable modes:
  - static value
  - counter slice with programmable shift
  - one-shot pulse
  - square wave
- Each channel drives WIDTH output bits, which are concatenated onto out_bus.

Parameters:
- CHANNELS, 8, number of independent output channels (1..32)
- WIDTH, 14, bits per channel (1..30)
- CNT_BITS, 32, width of the shared free-running counter
- SEL_BITS, 5, width of the channel-select fields (must satisfy 2^SEL_BITS >= CHANNELS)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_wr  in  1  single-cycle write strobe
- cfg_sel  in  SEL_BITS  channel index for the write
- cfg_data  in  32  configuration word: [31:30] mode, [29:0] arg
- out_bus  out  CHANNELS*WIDTH  registered outputs; channel k occupies bits [k*WIDTH +: WIDTH]
- busy  out  CHANNELS  per-channel flag, 1 while a pulse (mode 2) is active
- rd_sel  in  SEL_BITS  readback channel index (optional feature)
- rd_data  out  32  readback word (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - shared counter cnt = 0
  - every channel: mode = 0, arg = 0, timer = 0, phase = 0
  - out_bus = 0, busy = 0, rd_data = 0
- Shared counter: cnt increments by 1 every cycle and wraps modulo 2^CNT_BITS.
- Configuration write:
  - On a cfg_wr cycle with cfg_sel < CHANNELS, channel cfg_sel latches mode/arg, sets timer = 0 and phase = 0.
  - The new mode takes effect on out_bus at the next clock edge, i.e. 1-cycle latency from the cfg_wr edge to the output.
  - cfg_sel >= CHANNELS: the write is ignored and no state changes.
- Per-channel state machine, keyed by mode; outputs are registered and updated every cycle:
  - Mode 0 (STATIC): out = arg[WIDTH-1:0]; busy = 0.
  - Mode 1 (SLICE):
    - out = cnt[s +: WIDTH], where s = arg[4:0].
    - Bits whose index s+i >= CNT_BITS read as 0.
    - busy = 0.
  - Mode 2 (PULSE):
    - arg = 0: out = 0, busy = 0 immediately; no pulse is produced.
    - Otherwise out = all ones and busy = 1 for exactly arg cycles. timer counts 0..arg-1.
    - After the pulse, out = 0 and busy = 0. The channel stays in mode 2 in the idle state until it is rewritten.
  - Mode 3 (SQUARE):
    - Half-period is arg+1 cycles. timer counts 0..arg; at timer == arg it wraps to 0 and phase toggles.
    - out = all ones when phase = 1, else 0. The first half-period is low.
    - busy = 0.
- Rewrite mid-operation: a cfg_wr to a channel with an active pulse or square wave aborts it. Timer and phase restart from 0 under the new configuration; no glitch cycle is inserted.
- Channel independence: channels share only cnt. A write to channel j never disturbs channel k != j.
- Timer width: 30 bits, saturating is not needed because arg <= 2^30-1 bounds the count.
- rst asserted mid-pulse: the next edge forces the reset state and busy drops to 0.

Optional Feature:
- Macro: GPIO_BANK_READBACK_EN
- Defined:
  - rd_data is registered with 1-cycle latency: {mode, arg} of channel rd_sel.
  - rd_sel >= CHANNELS returns 0.
  - Intended to feed s3g_executor in_regN.
- Not defined:
  - rd_data is tied to 0 and rd_sel is unused.
  - No readback registers are synthesised.

Test Plan:
- Reset, then idle 10 cycles -> out_bus == 0, busy == 0, rd_data == 0.
- Write ch0 with mode 0, arg 0x2A5 -> out_bus[13:0] == 0x2A5 on the cycle after cfg_wr; all other channels remain 0.
- Write ch1 with mode 1, arg 12, then compare for 5000 cycles -> out_bus[27:14] == cnt[25:12] every cycle. Separately, with shift 25 and CNT_BITS = 32, the top 7 bits of the slice read 0.
- Write ch2 with mode 2, arg 5 -> busy[2] and all-ones output for exactly 5 cycles, then 0. Repeat with arg 0 -> no pulse. Rewrite with arg 3 at pulse cycle 2 -> the pulse restarts and lasts 3 cycles from the rewrite.
- Write ch3 with mode 3, arg 3 -> output is 4 cycles low, 4 high, repeating for 64 cycles. Assert rst mid-pattern -> output is 0 on the next cycle and stays 0.
- Write with cfg_sel = CHANNELS (8) -> no change on any output. With GPIO_BANK_READBACK_EN and ch0 = mode 0 / arg 0x2A5, setting rd_sel = 0 gives rd_data == 0x000002A5 one cycle later.
